// File: rtl/demux_stream.sv
// Registered 1-to-N_CH stream demultiplexer with directed, broadcast and round-robin routing.
// Each channel holds one word in an output register and can drain and refill on the same edge.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_CH-1:0]         out_valid,
  input  logic [N_CH-1:0]         out_ready,
  output logic [N_CH*WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    sel_err
);

  localparam logic [SEL_W:0]   N_CH_L  = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] RR_LAST = SEL_W'(N_CH - 1);

  logic [N_CH-1:0]       vld_p0;
  logic [N_CH*WIDTH-1:0] data_p0;
  logic [SEL_W-1:0]      rr_ptr_p0;
  logic                  sel_err_p0;

  logic [N_CH-1:0] free;
  logic [N_CH-1:0] load;
  logic            is_dir;
  logic            is_bcast;
  logic            is_rr;
  logic            sel_ok;
  logic            sel_free;
  logic            rr_free;
  logic            accept;

  always_comb begin
    free     = ~vld_p0 | out_ready;
    is_bcast = (mode == 2'b01);
    is_rr    = (mode == 2'b10);
    is_dir   = !is_bcast && !is_rr;
    sel_ok   = ({1'b0, in_sel} < N_CH_L);
    sel_free = 1'b0;
    rr_free  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (in_sel == SEL_W'(i))    sel_free = free[i];
      if (rr_ptr_p0 == SEL_W'(i)) rr_free  = free[i];
    end
    if (is_bcast)   in_ready = &free;
    else if (is_rr) in_ready = rr_free;
    else            in_ready = sel_ok ? sel_free : 1'b1;
    accept = in_valid & in_ready;
    load   = '0;
    // An out-of-range select matches no channel, so the word is simply dropped.
    for (int i = 0; i < N_CH; i++) begin
      load[i] = accept & (is_bcast
                          | (is_rr  & (rr_ptr_p0 == SEL_W'(i)))
                          | (is_dir & (in_sel == SEL_W'(i))));
    end
  end

  // Stage p0: per-channel output registers, round-robin pointer and error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0     <= '0;
      data_p0    <= '0;
      rr_ptr_p0  <= '0;
      sel_err_p0 <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (load[i]) begin
          vld_p0[i]                  <= 1'b1;
          data_p0[i*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[i]) begin
          vld_p0[i] <= 1'b0;
        end
      end
      if (accept && is_rr)
        rr_ptr_p0 <= (rr_ptr_p0 == RR_LAST) ? '0 : rr_ptr_p0 + SEL_W'(1);
      sel_err_p0 <= accept & is_dir & ~sel_ok;
    end
  end

  assign out_valid = vld_p0;
  assign out_data  = data_p0;
  assign rr_ptr    = rr_ptr_p0;
  assign sel_err   = sel_err_p0;

endmodule

// File: tb/tb_demux_stream.sv
// Randomized bench for demux_stream against a per-channel behavioural model.
// Uses N_CH=3 with SEL_W=2 so the out-of-range select path is exercised.
module tb_demux_stream;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [SW-1:0]     in_sel;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N*W-1:0]    out_data;
  logic [SW-1:0]     rr_ptr;
  logic              sel_err;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(W), .N_CH(N), .SEL_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .rr_ptr    (rr_ptr),
    .sel_err   (sel_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference state: one slot per channel, round-robin target, pending error pulse
  bit         mv[N];
  logic [W-1:0] md[N];
  int         mptr;
  bit         merr;

  function automatic bit m_free(int ch);
    return !mv[ch] || out_ready[ch];
  endfunction

  function automatic bit m_ready();
    bit all_free;
    all_free = 1'b1;
    for (int i = 0; i < N; i++) if (!m_free(i)) all_free = 1'b0;
    case (mode)
      2'b01:   return all_free;
      2'b10:   return m_free(mptr);
      default: return (int'(in_sel) >= N) ? 1'b1 : m_free(int'(in_sel));
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    mptr = 0;
    merr = 1'b0;
  endtask

  task automatic model_step();
    bit acc, dir, tgt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dir  = (mode == 2'b00) || (mode == 2'b11);
    acc  = in_valid && m_ready();
    merr = acc && dir && (int'(in_sel) >= N);
    for (int i = 0; i < N; i++) begin
      tgt = (mode == 2'b01) || (mode == 2'b10 && i == mptr) || (dir && int'(in_sel) == i);
      if (acc && tgt) begin
        mv[i] = 1'b1;
        md[i] = in_data;
      end else if (mv[i] && out_ready[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (acc && mode == 2'b10) mptr = (mptr + 1) % N;
  endtask

  task automatic compare_all();
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    for (int i = 0; i < N; i++) begin
      ev[i]         = mv[i];
      ed[i*W +: W]  = md[i];
    end
    check("in_ready",  64'(in_ready),  64'(m_ready()));
    check("out_valid", 64'(out_valid), 64'(ev));
    check("out_data",  64'(out_data),  64'(ed));
    check("rr_ptr",    64'(rr_ptr),    64'(mptr));
    check("sel_err",   64'(sel_err),   64'(merr));
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'b00;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_sel    = '0;
    out_ready = '1;
    model_reset();

    // Reset held with a word offered: nothing may be captured
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 compare_all();
      @(posedge clk);
      model_step();
    end

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      in_valid = ($urandom_range(0, 9) < 8);
      in_data  = 8'($urandom);
      in_sel   = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) out_ready[i] = ($urandom_range(0, 9) < 6);
      #1 compare_all();
      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    #1 compare_all();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
